// File: rtl/csa_accum_sched_pkg.sv
// Shared NPU package for the CSA accumulation scheduler.
// Provides: scheduler state enum, default operand width / operand count.
// No logic; types and constants only.
package csa_accum_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REDUCE = 2'd1,
      S_FINAL  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int DEF_W      = 8;
   localparam int DEF_NUM_OP = 8;

endpackage

// File: rtl/csa_accum_sched_compress_row.sv
// 5:3 compressor cell and one OW-wide row of them (one cell per bit column).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// csa_cell_5to3 ports : i_a..i_e (1b each) -> o_sum (w1), o_carry (w2), o_cout (w4)
// compress_row_5to3   : i_r0..i_r4 (OW each) -> o_sum, o_carry, o_cout (OW each, unshifted)

module csa_cell_5to3 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   input  logic i_d,
   input  logic i_e,
   output logic o_sum,
   output logic o_carry,
   output logic o_cout
);
   logic [2:0] w_cnt;

   // Population count of the five inputs, 0..5, split into weights 1/2/4.
   assign w_cnt = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d} + {2'b00, i_e};
   assign {o_cout, o_carry, o_sum} = w_cnt;
endmodule

module compress_row_5to3 #(
   parameter int OW = 11
) (
   input  logic [OW-1:0] i_r0,
   input  logic [OW-1:0] i_r1,
   input  logic [OW-1:0] i_r2,
   input  logic [OW-1:0] i_r3,
   input  logic [OW-1:0] i_r4,
   output logic [OW-1:0] o_sum,
   output logic [OW-1:0] o_carry,
   output logic [OW-1:0] o_cout
);
   // Columns are independent; the caller applies the <<1 / <<2 weights.
   for (genvar b = 0; b < OW; b++) begin : g_col
      csa_cell_5to3 u_cell (
         .i_a     (i_r0[b]),
         .i_b     (i_r1[b]),
         .i_c     (i_r2[b]),
         .i_d     (i_r3[b]),
         .i_e     (i_r4[b]),
         .o_sum   (o_sum[b]),
         .o_carry (o_carry[b]),
         .o_cout  (o_cout[b])
      );
   end
endmodule

// File: rtl/csa_accum_sched.sv
// Sums up to NUM_OP unsigned operands by reusing one 5:3 compressor row per cycle.
// Latency: out_valid rises R(n)+1 edges after acceptance (R = reduction rounds).
// Backpressure: one job in flight; in_ready low until the result is taken via out_ready.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data/in_count job input;
//        out_valid/out_ready/out_sum result output; busy = not idle.

module csa_accum_sched
   import csa_accum_sched_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int NUM_OP = DEF_NUM_OP,
   parameter int OW     = W + $clog2(NUM_OP)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_OP*W-1:0]          in_data,
   input  logic [$clog2(NUM_OP+1)-1:0]  in_count,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OW-1:0]                out_sum,
   output logic                         busy
);
   localparam int CW = $clog2(NUM_OP + 1);
   // Row buffer always has at least five rows so the compressor inputs exist.
   localparam int NB = (NUM_OP < 5) ? 5 : NUM_OP;
   // Counter wide enough to compare against 4 and 5 for any NUM_OP.
   localparam int NW = (CW < 3) ? 3 : CW;

   state_t          r_state;
   logic [OW-1:0]   r_rows [NB];
   logic [NW-1:0]   r_n;
   logic [OW-1:0]   r_out_sum;
   logic            r_out_valid;

   logic [CW-1:0]   w_cnt_clamp;
   logic [NW-1:0]   w_cnt;
   logic [OW-1:0]   w_load [NB];
   logic [OW-1:0]   w_next [NB];
   logic [OW-1:0]   w_s, w_c, w_d;
   logic [NW-1:0]   w_n_next;
   logic [OW-1:0]   w_final;

   assign w_cnt_clamp = (in_count > CW'(NUM_OP)) ? CW'(NUM_OP) : in_count;
   assign w_cnt       = NW'(w_cnt_clamp);

   // Operand k is loaded only if it is among the first cnt; all else is zero.
   for (genvar k = 0; k < NB; k++) begin : g_load
      if (k < NUM_OP) begin : g_op
         assign w_load[k] = (NW'(k) < w_cnt) ? OW'(in_data[k*W +: W]) : '0;
      end else begin : g_pad
         assign w_load[k] = '0;
      end
   end

   compress_row_5to3 #(.OW(OW)) u_row (
      .i_r0    (r_rows[0]),
      .i_r1    (r_rows[1]),
      .i_r2    (r_rows[2]),
      .i_r3    (r_rows[3]),
      .i_r4    (r_rows[4]),
      .o_sum   (w_s),
      .o_carry (w_c),
      .o_cout  (w_d)
   );

   // Three compressed rows go to the bottom; untouched rows 5.. slide down by two.
   for (genvar j = 0; j < NB; j++) begin : g_next
      if (j == 0) begin : g_s
         assign w_next[j] = w_s;
      end else if (j == 1) begin : g_c
         assign w_next[j] = w_c << 1;
      end else if (j == 2) begin : g_d
         assign w_next[j] = w_d << 2;
      end else if (j + 2 < NB) begin : g_shift
         assign w_next[j] = r_rows[j+2];
      end else begin : g_clear
         assign w_next[j] = '0;
      end
   end

   // Five or more rows shrink by two; exactly four collapse to three.
   assign w_n_next = (r_n >= NW'(5)) ? (r_n - NW'(2)) : NW'(3);
   assign w_final  = r_rows[0] + r_rows[1] + r_rows[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rows      <= '{default: '0};
         r_n         <= '0;
         r_out_sum   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_rows  <= w_load;
                  r_n     <= w_cnt;
                  r_state <= (w_cnt >= NW'(4)) ? S_REDUCE : S_FINAL;
               end
            end
            S_REDUCE: begin
               r_rows <= w_next;
               r_n    <= w_n_next;
               if (w_n_next <= NW'(3)) begin
                  r_state <= S_FINAL;
               end
            end
            S_FINAL: begin
               r_out_sum   <= w_final;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;

endmodule
